// File: rtl/minion_uart_pkg.sv
// minion_uart_pkg: shared constants and types for the minion UART.
//   - register word offsets (core_lsu_addr[5:2])
//   - STATUS bit indices
//   - uart_state_e: state encoding shared by the TX and RX engines
//   - eff_baud(): clamps the programmed divisor to the minimum usable value
package minion_uart_pkg;

  localparam logic [3:0] REG_TXDATA = 4'd0;
  localparam logic [3:0] REG_BAUD   = 4'd1;
  localparam logic [3:0] REG_RXDATA = 4'd2;
  localparam logic [3:0] REG_STATUS = 4'd3;
  localparam logic [3:0] REG_CTRL   = 4'd4;

  localparam int ST_TX_BUSY  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_RX_FE    = 5;

  localparam logic [15:0] BAUD_MIN = 16'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // Below 4 clocks/bit the half-bit start check and sync latency collide.
  function automatic logic [15:0] eff_baud(input logic [15:0] b);
    return (b < BAUD_MIN) ? BAUD_MIN : b;
  endfunction

endpackage

// File: rtl/minion_uart_fifo_if.sv
// minion_uart_fifo_if: core LSU slot bus for the minion UART.
//   req/we/addr/wdata : master -> slave request (req already slot-decoded)
//   gnt               : slave -> master, combinational grant
//   rvalid/rdata      : slave -> master, response one cycle after grant
interface minion_uart_fifo_if;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
  modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/minion_sync_fifo.sv
// minion_sync_fifo: single-clock FIFO with show-ahead output.
//   clk_i, rst_ni : clock, async active-low reset (pointers/count only)
//   push_i, din_i : write; ignored when full unless a pop happens the same cycle
//   pop_i, dout_o : read; dout_o always shows the head, pop on empty ignored
//   count_o       : occupancy, $clog2(DEPTH)+1 bits
//   full_o, empty_o
// DEPTH must be a power of two so the pointers wrap naturally.
module minion_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot in the same cycle, so push-on-full with pop succeeds.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/minion_uart_fifo.sv
// minion_uart_fifo: memory-mapped UART with TX/RX FIFOs and sticky error flags.
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : minion_uart_fifo_if.slave (req/we/addr/wdata -> gnt/rvalid/rdata)
//   uart_tx_o     : serial out, idles high
//   uart_rx_i     : asynchronous serial in
//   irq_o         : registered interrupt, only with MINION_UART_IRQ_EN defined
// Registers: 0 TXDATA(W) 1 BAUD(RW) 2 RXDATA(R, pop) 3 STATUS(R, W1C [5:3]) 4 CTRL(RW)
// Build option MINION_UART_IRQ_EN: implements CTRL and irq_o; otherwise CTRL reads 0.
module minion_uart_fifo
  import minion_uart_pkg::*;
#(
  parameter int          TX_DEPTH = 16,
  parameter int          RX_DEPTH = 16,
  parameter logic [15:0] BAUD_RST = 16'd651
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  minion_uart_fifo_if.slave   bus,
  output logic                uart_tx_o,
  input  logic                uart_rx_i
`ifdef MINION_UART_IRQ_EN
  ,
  output logic                irq_o
`endif
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  // ---------------- bus decode ----------------
  logic wr, rd;
  assign bus.gnt = bus.req;
  assign wr      = bus.req &  bus.we;
  assign rd      = bus.req & ~bus.we;

  logic [15:0] baud_q, baud_eff, bit_m1, half_m1;
  assign baud_eff = eff_baud(baud_q);
  assign bit_m1   = baud_eff - 16'd1;
  assign half_m1  = (baud_eff >> 1) - 16'd1;

  // ---------------- FIFOs ----------------
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]     tx_head;
  logic [TCW-1:0] tx_cnt;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [8:0]     rx_head, rx_din;
  logic [RCW-1:0] rx_cnt;

  assign tx_push = wr & (bus.addr == REG_TXDATA);
  assign rx_pop  = rd & (bus.addr == REG_RXDATA) & ~rx_empty;

  minion_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(tx_push), .pop_i(tx_pop),
    .din_i(bus.wdata[7:0]), .dout_o(tx_head), .count_o(tx_cnt),
    .full_o(tx_full), .empty_o(tx_empty)
  );

  minion_sync_fifo #(.WIDTH(9), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(rx_push), .pop_i(rx_pop),
    .din_i(rx_din), .dout_o(rx_head), .count_o(rx_cnt),
    .full_o(rx_full), .empty_o(rx_empty)
  );

  // ---------------- TX engine ----------------
  // Timer reloads from the live divisor only at bit boundaries, so a BAUD
  // write never stretches or truncates the bit in flight.
  uart_state_e tx_st_q;
  logic [15:0] tx_tmr_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_sh_q;
  logic        tx_q, tx_tick, tx_busy;

  assign tx_tick   = (tx_tmr_q == '0);
  assign tx_busy   = (tx_st_q != IDLE);
  // Popping at the end of STOP chains frames with no idle gap.
  assign tx_pop    = ~tx_empty & ((tx_st_q == IDLE) | ((tx_st_q == STOP) & tx_tick));
  assign uart_tx_o = tx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_st_q  <= IDLE;
      tx_tmr_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (tx_st_q)
        IDLE: if (tx_pop) begin
          tx_st_q  <= START;
          tx_q     <= 1'b0;
          tx_sh_q  <= tx_head;
          tx_tmr_q <= bit_m1;
        end
        START: if (tx_tick) begin
          tx_st_q  <= DATA;
          tx_q     <= tx_sh_q[0];
          tx_sh_q  <= tx_sh_q >> 1;
          tx_bit_q <= '0;
          tx_tmr_q <= bit_m1;
        end else tx_tmr_q <= tx_tmr_q - 16'd1;
        DATA: if (tx_tick) begin
          tx_tmr_q <= bit_m1;
          if (tx_bit_q == 3'd7) begin
            tx_st_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            tx_bit_q <= tx_bit_q + 3'd1;
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end
        end else tx_tmr_q <= tx_tmr_q - 16'd1;
        STOP: if (tx_tick) begin
          if (tx_pop) begin
            tx_st_q  <= START;
            tx_q     <= 1'b0;
            tx_sh_q  <= tx_head;
            tx_tmr_q <= bit_m1;
          end else tx_st_q <= IDLE;
        end else tx_tmr_q <= tx_tmr_q - 16'd1;
        default: tx_st_q <= IDLE;
      endcase
    end
  end

  // ---------------- RX engine ----------------
  logic [1:0]  rx_sync_q;
  logic        rx_prev_q, rx_s, rx_tick;
  uart_state_e rx_st_q;
  logic [15:0] rx_tmr_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;

  assign rx_s    = rx_sync_q[1];
  assign rx_tick = (rx_tmr_q == '0);
  // Push at the stop-bit centre; frame_err is the inverted stop sample.
  assign rx_push = (rx_st_q == STOP) & rx_tick;
  assign rx_din  = {~rx_s, rx_sh_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      rx_st_q   <= IDLE;
      rx_tmr_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx_i};
      rx_prev_q <= rx_s;
      case (rx_st_q)
        IDLE: if (rx_prev_q & ~rx_s) begin
          rx_st_q  <= START;
          rx_tmr_q <= half_m1;
        end
        // Mid-start recheck rejects glitches shorter than half a bit.
        START: if (rx_tick) begin
          if (rx_s) rx_st_q <= IDLE;
          else begin
            rx_st_q  <= DATA;
            rx_bit_q <= '0;
            rx_tmr_q <= bit_m1;
          end
        end else rx_tmr_q <= rx_tmr_q - 16'd1;
        DATA: if (rx_tick) begin
          rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
          rx_tmr_q <= bit_m1;
          if (rx_bit_q == 3'd7) rx_st_q <= STOP;
          else rx_bit_q <= rx_bit_q + 3'd1;
        end else rx_tmr_q <= rx_tmr_q - 16'd1;
        STOP: if (rx_tick) rx_st_q <= IDLE;
              else rx_tmr_q <= rx_tmr_q - 16'd1;
        default: rx_st_q <= IDLE;
      endcase
    end
  end

  // ---------------- sticky flags / registers ----------------
  logic       tx_ovf_q, rx_ovf_q, rx_fe_q;
  logic       tx_ovf_d, rx_ovf_d, rx_fe_d;
  logic [2:0] clr;   // {RX_FE, RX_OVF, TX_OVF}

  always_comb begin
    clr = '0;
    if (wr && bus.addr == REG_STATUS) clr = bus.wdata[ST_RX_FE:ST_TX_OVF];
    // Set terms are OR-ed last so a same-cycle event beats the clear.
    tx_ovf_d = (tx_ovf_q & ~clr[0]) | (tx_push & tx_full & ~tx_pop);
    rx_ovf_d = (rx_ovf_q & ~clr[1]) | (rx_push & rx_full & ~rx_pop);
    rx_fe_d  = (rx_fe_q  & ~clr[2]) | (rx_push & ~rx_s);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      rx_fe_q  <= 1'b0;
      baud_q   <= BAUD_RST;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      rx_fe_q  <= rx_fe_d;
      if (wr && bus.addr == REG_BAUD) baud_q <= bus.wdata[15:0];
    end
  end

`ifdef MINION_UART_IRQ_EN
  logic [2:0] ctrl_q;
  logic       irq_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && bus.addr == REG_CTRL) ctrl_q <= bus.wdata[2:0];
      irq_q <= |(ctrl_q & {rx_fe_q | rx_ovf_q, tx_empty & ~tx_busy, rx_cnt != '0});
    end
  end
  assign irq_o = irq_q;
`endif

  // ---------------- read path ----------------
  logic [31:0] rdata_d, rdata_q;
  logic        rvalid_q;

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (bus.addr)
        REG_BAUD:   rdata_d = {16'b0, baud_q};
        REG_RXDATA: if (!rx_empty) rdata_d = {22'b0, 1'b1, rx_head};
        REG_STATUS: begin
          rdata_d[31:24]       = 8'(rx_cnt);
          rdata_d[23:16]       = 8'(tx_cnt);
          rdata_d[ST_RX_FE]    = rx_fe_q;
          rdata_d[ST_RX_OVF]   = rx_ovf_q;
          rdata_d[ST_TX_OVF]   = tx_ovf_q;
          rdata_d[ST_RX_FULL]  = rx_full;
          rdata_d[ST_TX_EMPTY] = tx_empty;
          rdata_d[ST_TX_BUSY]  = tx_busy;
        end
`ifdef MINION_UART_IRQ_EN
        REG_CTRL:   rdata_d = {29'b0, ctrl_q};
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus.req;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

endmodule

// File: tb/tb_minion_uart_fifo.sv
`timescale 1ns/1ps
module tb_minion_uart_fifo;
  localparam logic [3:0] A_TXDATA = 4'd0, A_BAUD = 4'd1, A_RXDATA = 4'd2,
                         A_STATUS = 4'd3, A_CTRL = 4'd4;
  localparam int DEPTH = 16;

  logic clk, rst_n, rx_line, tx_line;
  minion_uart_fifo_if bus();
`ifdef MINION_UART_IRQ_EN
  logic irq;
`endif

  minion_uart_fifo dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .uart_tx_o(tx_line), .uart_rx_i(rx_line)
`ifdef MINION_UART_IRQ_EN
    , .irq_o(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int eff = 651;            // clocks per bit the line is expected to use
  bit ignore_tx = 1'b0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [8:0]  rx_model[$]; // {frame_err, byte}
  bit fe_m = 0, rx_ovf_m = 0, tx_ovf_m = 0;
  logic mon_req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status(input int txn, input bit busy);
    logic [31:0] s;
    s = '0;
    s[31:24] = 8'(rx_model.size());
    s[23:16] = 8'(txn);
    s[5] = fe_m; s[4] = rx_ovf_m; s[3] = tx_ovf_m;
    s[2] = (rx_model.size() == DEPTH);
    s[1] = (txn == 0);
    s[0] = busy;
    return s;
  endfunction

  task automatic bus_op(input bit we, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = we; bus.addr = a; bus.wdata = d;
    rd_exp_q.push_back(exp); rd_name_q.push_back(name);
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    bus_op(1'b1, a, d, 32'h0, "wr_rdata");
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    bus_op(1'b0, a, 32'h0, exp, name);
  endtask

  task automatic rd_rxdata();
    logic [31:0] e;
    e = 32'h0;
    if (rx_model.size() > 0) e = {22'b0, 1'b1, rx_model.pop_front()};
    bus_rd(A_RXDATA, e, "rxdata");
  endtask

  task automatic w1c(input logic [31:0] d);
    bus_wr(A_STATUS, d);
    if (d[3]) tx_ovf_m = 0;
    if (d[4]) rx_ovf_m = 0;
    if (d[5]) fe_m = 0;
  endtask

  task automatic set_baud(input logic [15:0] b);
    bus_wr(A_BAUD, {16'h0, b});
    eff = (b < 4) ? 4 : int'(b);
  endtask

  // Drive one frame, then one bit of idle; model records what must land in RX.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; rx_line = f[i];
      repeat (eff - 1) @(posedge clk);
    end
    @(posedge clk); #1; rx_line = 1'b1;
    repeat (eff) @(posedge clk);
    if (rx_model.size() < DEPTH) rx_model.push_back({~stop, b});
    else rx_ovf_m = 1;
    if (!stop) fe_m = 1;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    tx_exp_q.push_back(b);
    bus_wr(A_TXDATA, {24'h0, b});
  endtask

  // Bus response monitor.
  initial begin : bus_mon
    forever begin
      @(negedge clk);
      if (bus.req) check("gnt", {31'b0, bus.gnt}, 32'h1);
      if (mon_req_prev || bus.rvalid) check("rvalid_timing", {31'b0, bus.rvalid}, {31'b0, mon_req_prev});
      if (bus.rvalid) begin
        if (rd_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata: unexpected response 0x%08h, nothing expected", bus.rdata);
        end else check(rd_name_q.pop_front(), bus.rdata, rd_exp_q.pop_front());
      end
      mon_req_prev = bus.req;
    end
  end

  // Serial TX decoder: samples bit centres at the configured rate.
  initial begin : tx_mon
    logic prev, ok;
    logic [7:0] b;
    int be;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx_line === 1'b0) begin
        be = eff;
        repeat (be / 2) @(negedge clk);
        ok = (tx_line === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (be) @(negedge clk);
          b[i] = tx_line;
        end
        repeat (be) @(negedge clk);
        ok = ok & (tx_line === 1'b1);
        if (!ignore_tx) begin
          if (tx_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_byte: unexpected frame 0x%02h", b);
          end else check("tx_byte", {23'b0, ok, b}, {23'b0, 1'b1, tx_exp_q.pop_front()});
        end
      end
      prev = tx_line;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t, n, cnt;
    logic lvl;
    logic [7:0] b;
    rst_n = 1'b0; rx_line = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    #12;
    check("rst_tx", {31'b0, tx_line}, 32'h1);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    bus_rd(A_BAUD, 32'd651, "baud_rst");
    bus_rd(A_STATUS, model_status(0, 0), "status_rst");
    bus_wr(A_CTRL, 32'h7);
`ifdef MINION_UART_IRQ_EN
    bus_rd(A_CTRL, 32'h7, "ctrl_rw");
    repeat (2) @(posedge clk);
    check("irq_tx_empty", {31'b0, irq}, 32'h1);
    bus_wr(A_CTRL, 32'h0);
`else
    bus_rd(A_CTRL, 32'h0, "ctrl_absent");
`endif

    // 0x55 at 16 clocks/bit: every run on the line is exactly one bit long.
    set_baud(16);
    bus_rd(A_BAUD, 32'd16, "baud_rw");
    tx_byte(8'h55);
    t = 0;
    while (tx_line === 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("tx_start_seen", {31'b0, t < 200}, 32'h1);
    for (int r = 0; r < 9; r++) begin
      lvl = tx_line; n = 0;
      while (tx_line === lvl && n < 100) begin @(negedge clk); n++; end
      check("tx_bit_len", n, 32'd16);
    end
    repeat (20) @(posedge clk);
    bus_rd(A_STATUS, model_status(0, 0), "status_tx_idle");

    // TX overflow: engine busy with a primer, then 17 pushes into 16 slots.
    tx_byte(8'($urandom));
    repeat (4) @(posedge clk);
    cnt = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (cnt < DEPTH) begin tx_byte(b); cnt++; end
      else begin bus_wr(A_TXDATA, {24'h0, b}); tx_ovf_m = 1; end
    end
    bus_rd(A_STATUS, model_status(cnt, 1), "status_tx_ovf");
    w1c(32'h08);
    bus_rd(A_STATUS, model_status(cnt, 1), "status_tx_w1c");
    repeat ((DEPTH + 1) * 160 + 100) @(posedge clk);
    bus_rd(A_STATUS, model_status(0, 0), "status_tx_drained");

    // Divisor below the floor runs at 4 clocks/bit.
    b = 8'($urandom_range(0, 3));
    set_baud({8'h0, b});
    bus_rd(A_BAUD, {24'h0, b}, "baud_small");
    for (int i = 0; i < 3; i++) tx_byte(8'($urandom));
    repeat (3 * 40 + 40) @(posedge clk);

    // Random divisor, random TX and RX bytes.
    set_baud(16'($urandom_range(5, 24)));
    for (int i = 0; i < 3; i++) tx_byte(8'($urandom));
    repeat (3 * 10 * eff + 40) @(posedge clk);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    bus_rd(A_STATUS, model_status(0, 0), "status_rx3");
    for (int i = 0; i < 4; i++) rd_rxdata();
    check("tx_all_sent", tx_exp_q.size(), 32'd0);

    // RX basics at 16 clocks/bit.
    set_baud(16);
    send_frame(8'hA3, 1'b1);
    bus_rd(A_STATUS, model_status(0, 0), "status_rx1");
    rd_rxdata();
    bus_rd(A_STATUS, model_status(0, 0), "status_rx0");
    rd_rxdata();
    send_frame(8'h3C, 1'b0);
    bus_rd(A_STATUS, model_status(0, 0), "status_fe");
    rd_rxdata();
    w1c(32'h20);
    bus_rd(A_STATUS, model_status(0, 0), "status_fe_clr");

    // Short low glitch must not start a frame.
    @(posedge clk); #1; rx_line = 1'b0;
    repeat (5) @(posedge clk); #1; rx_line = 1'b1;
    repeat (40) @(posedge clk);
    bus_rd(A_STATUS, model_status(0, 0), "status_glitch");

    // RX overflow.
`ifdef MINION_UART_IRQ_EN
    bus_wr(A_CTRL, 32'h1);
`endif
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_frame(8'($urandom), 1'b1);
`ifdef MINION_UART_IRQ_EN
      if (i == 0) check("irq_rise", {31'b0, irq}, 32'h1);
`endif
    end
    bus_rd(A_STATUS, model_status(0, 0), "status_rx_ovf");
    for (int i = 0; i < DEPTH; i++) rd_rxdata();
`ifdef MINION_UART_IRQ_EN
    repeat (3) @(posedge clk);
    check("irq_fall", {31'b0, irq}, 32'h0);
`endif
    rd_rxdata();
    w1c(32'h38);
    bus_rd(A_STATUS, model_status(0, 0), "status_all_clr");

    // Reset in the middle of a TX frame.
    ignore_tx = 1'b1;
    bus_wr(A_TXDATA, 32'h000000F0);
    repeat (64) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("rst_mid_tx", {31'b0, tx_line}, 32'h1);
    rx_model.delete(); fe_m = 0; rx_ovf_m = 0; tx_ovf_m = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    eff = 651;
    bus_rd(A_BAUD, 32'd651, "baud_after_rst");
    bus_rd(A_STATUS, model_status(0, 0), "status_after_rst");
    repeat (200) @(posedge clk);
    check("bus_all_responded", rd_exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
